// File: rtl/wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wr_ctrl_pkg
// Shared definitions for the Avalon-MM write burst controller:
//   - state_e     : controller FSM state encoding
//   - BOUNDARY_4K : size of the address window that bursts must not cross
//                   (only used when WR_BURST_CTRL_4K_BOUNDARY_EN is defined)
//   - min3()      : unsigned minimum of three 32-bit values
// -----------------------------------------------------------------------------
package wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAN  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [12:0] BOUNDARY_4K = 13'd4096;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    m = (m < c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/wr_burst_planner.sv
// -----------------------------------------------------------------------------
// wr_burst_planner
// Computes the beat count of the next burst and holds it in a register
// (one cycle latency from i_load).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : capture a new burst length this cycle
//   i_remaining    : words still to be written for the packet
//   i_addr_lo      : low 12 bits of the burst start address
//                    (port exists only with WR_BURST_CTRL_4K_BOUNDARY_EN)
//   o_beats        : registered burst length (Avalon burstcount)
// Configuration macro: WR_BURST_CTRL_4K_BOUNDARY_EN
// -----------------------------------------------------------------------------
module wr_burst_planner
  import wr_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int BC_W      = $clog2(MAX_BURST) + 1
`ifdef WR_BURST_CTRL_4K_BOUNDARY_EN
  , parameter int OFF_W   = 2
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [31:0]     i_remaining,
`ifdef WR_BURST_CTRL_4K_BOUNDARY_EN
  input  logic [11:0]     i_addr_lo,
`endif
  output logic [BC_W-1:0] o_beats
);

  logic [31:0]     w_limit;
  logic [BC_W-1:0] r_beats;

`ifdef WR_BURST_CTRL_4K_BOUNDARY_EN
  logic [12:0] w_room;

  // Words left before the next 4 KiB boundary; address is word aligned so
  // this is always at least one.
  always_comb begin
    w_room = (BOUNDARY_4K - {1'b0, i_addr_lo}) >> OFF_W;
  end

  assign w_limit = {19'd0, w_room};
`else
  assign w_limit = 32'(MAX_BURST);
`endif

  // Burst length register, loaded once per PLAN cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beats <= {BC_W{1'b0}};
    end else if (i_load) begin
      r_beats <= BC_W'(min3(i_remaining, 32'(MAX_BURST), w_limit));
    end
  end

  assign o_beats = r_beats;

endmodule

// File: rtl/wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// wr_burst_ctrl
// Moves one packet from a show-ahead FIFO to memory as a series of Avalon-MM
// write bursts.
//   clk, reset                 : clock, async active-low reset
//   start                      : packet request, sampled only while rdy=1
//   pkt_begin, pkt_end         : packet byte offsets (len = end - begin)
//   write_address              : base byte address
//   fifo_empty, fifo_out       : show-ahead FIFO status and head word
//   rd_from_fifo               : FIFO pop (one per accepted beat)
//   rdy                        : idle / ready for start
//   done                       : one-cycle completion pulse
//   address, writedata, byteenable, write, burstcount, waitrequest :
//                                Avalon-MM burst master
// Configuration macro: WR_BURST_CTRL_4K_BOUNDARY_EN keeps every burst inside
// one 4 KiB window.
// -----------------------------------------------------------------------------
module wr_burst_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  pkt_begin,
  input  logic [31:0]                  pkt_end,
  input  logic [ADDR_W-1:0]            write_address,
  input  logic                         fifo_empty,
  input  logic [DATA_W-1:0]            fifo_out,
  output logic                         rd_from_fifo,
  output logic                         rdy,
  output logic                         done,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            writedata,
  output logic [DATA_W/8-1:0]          byteenable,
  output logic                         write,
  output logic [$clog2(MAX_BURST):0]   burstcount,
  input  logic                         waitrequest
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int BC_W  = $clog2(MAX_BURST) + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_remaining;
  logic [OFF_W-1:0]  r_tail;
  logic [BC_W-1:0]   r_beat_cnt;

  logic [BC_W-1:0]   w_beats;
  logic [31:0]       w_len;
  logic [31:0]       w_words;
  logic [ADDR_W-1:0] w_start_addr;
  logic              w_in_burst;
  logic              w_write;
  logic              w_beat_ok;
  logic              w_last_beat;
  logic              w_final_word;
  logic [BYTES-1:0]  w_be;

  assign w_len        = pkt_end - pkt_begin;
  // ceil(len / BYTES) without widening the 32-bit length.
  assign w_words      = (w_len >> OFF_W) + {31'd0, (w_len[OFF_W-1:0] != {OFF_W{1'b0}})};
  assign w_start_addr = (write_address + ADDR_W'(pkt_begin)) & ~ADDR_W'(BYTES - 1);

  wr_burst_planner #(
    .MAX_BURST (MAX_BURST),
    .BC_W      (BC_W)
`ifdef WR_BURST_CTRL_4K_BOUNDARY_EN
    , .OFF_W   (OFF_W)
`endif
  ) u_planner (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_load      (r_state == ST_PLAN),
    .i_remaining (r_remaining),
`ifdef WR_BURST_CTRL_4K_BOUNDARY_EN
    .i_addr_lo   (r_addr[11:0]),
`endif
    .o_beats     (w_beats)
  );

  // Beat handshake: write follows FIFO data, a beat is taken when the slave
  // is not stalling, and only then is the FIFO popped.
  assign w_in_burst   = (r_state == ST_BURST);
  assign w_write      = w_in_burst & ~fifo_empty;
  assign w_beat_ok    = w_write & ~waitrequest;
  assign w_last_beat  = (r_beat_cnt == (w_beats - BC_W'(1)));
  // r_remaining only drops at burst end, so subtract the beats already taken.
  assign w_final_word = ((r_remaining - 32'(r_beat_cnt)) == 32'd1);

  // Byte lanes: partial mask only on the packet's last word with a tail.
  always_comb begin
    if (!w_in_burst) begin
      w_be = {BYTES{1'b0}};
    end else if (w_final_word && (r_tail != {OFF_W{1'b0}})) begin
      w_be = ~({BYTES{1'b1}} << r_tail);
    end else begin
      w_be = {BYTES{1'b1}};
    end
  end

  // Controller FSM with packet address/length bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_remaining <= 32'd0;
      r_tail      <= {OFF_W{1'b0}};
      r_beat_cnt  <= {BC_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= w_start_addr;
            r_remaining <= w_words;
            r_tail      <= w_len[OFF_W-1:0];
            r_beat_cnt  <= {BC_W{1'b0}};
            r_state     <= (pkt_end > pkt_begin) ? ST_PLAN : ST_DONE;
          end
        end
        ST_PLAN: begin
          r_beat_cnt <= {BC_W{1'b0}};
          r_state    <= ST_BURST;
        end
        ST_BURST: begin
          if (w_beat_ok) begin
            if (w_last_beat) begin
              r_addr      <= r_addr + (ADDR_W'(w_beats) << OFF_W);
              r_remaining <= r_remaining - 32'(w_beats);
              r_beat_cnt  <= {BC_W{1'b0}};
              r_state     <= (r_remaining == 32'(w_beats)) ? ST_DONE : ST_PLAN;
            end else begin
              r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign write        = w_write;
  assign rd_from_fifo = w_beat_ok;
  assign writedata    = w_in_burst ? fifo_out : {DATA_W{1'b0}};
  assign byteenable   = w_be;
  assign address      = r_addr;
  assign burstcount   = w_beats;
  assign rdy          = (r_state == ST_IDLE);
  assign done         = (r_state == ST_DONE);

endmodule
